// File: rtl/sa_pkg.sv
// sa_pkg: shared types, default sizes and index helpers for the systolic-array scheduler.
`timescale 1ns/1ps
package sa_pkg;
  localparam int SA_N = 4;
  localparam int SA_MAX_VEC = 256;
  localparam int SA_CNT_W = $clog2(SA_MAX_VEC + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} sa_state_t;
  function automatic logic [SA_CNT_W-1:0] row_idx(input logic [SA_N*SA_CNT_W-1:0] v, input int i);
    return v[i*SA_CNT_W +: SA_CNT_W];
  endfunction
endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: D-stage delay line of {valid, idx}; every valid stage is tapped, idx only from stage T up.
`timescale 1ns/1ps
module sa_skew_line #(
  parameter int D = 8,
  parameter int W = 9,
  parameter int T = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vin,
  input  logic [W-1:0]       din,
  output logic [D-1:0]       vld,
  output logic [(D-T)*W-1:0] idx
);
  logic [D*W-1:0] sr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld <= '0;
      sr  <= '0;
    end else begin
      vld <= {vld[D-2:0], vin};
      sr  <= {sr[(D-1)*W-1:0], din};
    end
  assign idx = sr[D*W-1 -: (D-T)*W];
endmodule

// File: rtl/sa_sched_ctrl.sv
// sa_sched_ctrl: job sequencer for an N x N weight-stationary systolic array
// (weight load, skewed activation stream, drain, result strobes, overflow capture).
`timescale 1ns/1ps
module sa_sched_ctrl
  import sa_pkg::*;
#(
  parameter int N       = SA_N,
  parameter int MAX_VEC = SA_MAX_VEC,
  parameter int CNT_W   = $clog2(MAX_VEC + 1),
  parameter int RW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               w_rd_en,
  output logic [RW-1:0]      w_rd_addr,
  output logic [N-1:0]       w_load_row,
  output logic               act_rd_en,
  output logic [CNT_W-1:0]   act_rd_addr,
  output logic [N-1:0]       col_enable,
  output logic [N-1:0]       res_valid,
  output logic [N*CNT_W-1:0] res_vec_idx,
  input  logic [N-1:0]       ovf_in,
  output logic               ovf_err,
  output logic [31:0]        busy_cycles
);
  sa_state_t st, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, nv;
  logic [2*N-1:0] vld;
  logic accept;
  always_comb begin
    nxt = st;
    accept = 1'b0;
    case (st)
      IDLE: if (start) begin
        accept = 1'b1;
        nxt = (num_vec == '0) ? DONE : LOAD_W;
      end
      LOAD_W: if (cnt == CNT_W'(N - 1)) nxt = STREAM;
      STREAM: if (cnt == nv - 1'b1) nxt = DRAIN;
      DRAIN: if (cnt == CNT_W'(2 * N - 1)) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_nxt = (nxt != st || st == IDLE) ? '0 : cnt + 1'b1;
  end
  assign busy        = st != IDLE;
  assign done        = st == DONE;
  assign w_rd_en     = st == LOAD_W;
  assign w_rd_addr   = w_rd_en ? cnt[RW-1:0] : '0;
  assign act_rd_en   = st == STREAM;
  assign act_rd_addr = act_rd_en ? cnt : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st          <= IDLE;
      cnt         <= '0;
      nv          <= '0;
      w_load_row  <= '0;
      ovf_err     <= 1'b0;
      busy_cycles <= '0;
    end else begin
      st          <= nxt;
      cnt         <= cnt_nxt;
      if (accept) nv <= (num_vec > CNT_W'(MAX_VEC)) ? CNT_W'(MAX_VEC) : num_vec;
      w_load_row  <= w_rd_en ? {{(N-1){1'b0}}, 1'b1} << w_rd_addr : '0;
      ovf_err     <= accept ? 1'b0 : ovf_err | (|(ovf_in & res_valid));
      busy_cycles <= accept ? 32'd1 :
                     (nxt != IDLE && busy_cycles != '1) ? busy_cycles + 32'd1 : busy_cycles;
    end
  // Stage k of the line is the feed delayed k: columns tap 0..N-1, row results tap N..2N-1.
  sa_skew_line #(.D(2 * N), .W(CNT_W), .T(N)) u_skew (
    .clk (clk),
    .rst (rst),
    .vin (act_rd_en),
    .din (act_rd_addr),
    .vld (vld),
    .idx (res_vec_idx)
  );
  assign col_enable = vld[N-1:0];
  assign res_valid  = vld[2*N-1:N];
endmodule

// File: tb/tb_sa_sched_ctrl.sv
// tb_sa_sched_ctrl: directed self-checking bench for sa_sched_ctrl (N=4).
`timescale 1ns/1ps
module tb_sa_sched_ctrl;
  import sa_pkg::*;
  localparam int N  = SA_N;
  localparam int CW = SA_CNT_W;
  localparam int MV = SA_MAX_VEC;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic [N-1:0] ovf_in = '0;
  logic busy, done, w_rd_en, act_rd_en, ovf_err;
  logic [1:0] w_rd_addr;
  logic [N-1:0] w_load_row, col_enable, res_valid;
  logic [CW-1:0] act_rd_addr;
  logic [N*CW-1:0] res_vec_idx;
  logic [31:0] busy_cycles;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sa_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_load_row(w_load_row),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .col_enable(col_enable),
    .res_valid(res_valid), .res_vec_idx(res_vec_idx), .ovf_in(ovf_in),
    .ovf_err(ovf_err), .busy_cycles(busy_cycles)
  );
  function automatic logic [62:0] obs();
    return {busy, done, w_rd_en, w_rd_addr, w_load_row, act_rd_en, act_rd_addr,
            col_enable, res_valid, res_vec_idx};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input int nv);
    num_vec = CW'(nv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int limit);
    int k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done timeout: got %b want 1 after %0d cycles", name, done, k);
    end
  endtask
  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_chk++;
    if ({obs(), ovf_err, busy_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h want 0", {obs(), ovf_err, busy_cycles});
    end
    start = 1'b1;
    num_vec = CW'(3);
    tick();
    tick();
    n_chk++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset held start ignored: got %h want 0", obs());
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask
  task automatic test_stream();
    logic eb, ed, ew, ea;
    logic [1:0] ewa;
    logic [N-1:0] elr, ecol, erv;
    logic [CW-1:0] eaa;
    logic [N*CW-1:0] eix;
    logic [62:0] e;
    launch(3);
    for (int c = 1; c <= 18; c++) begin
      eb = c <= 16;
      ed = c == 16;
      ew = c <= 4;
      ewa = ew ? 2'(c - 1) : 2'd0;
      elr = (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'd0;
      ea = c >= 5 && c <= 7;
      eaa = ea ? CW'(c - 5) : '0;
      for (int j = 0; j < N; j++) begin
        ecol[j] = c >= 6 + j && c <= 8 + j;
        erv[j] = c >= 10 + j && c <= 12 + j;
        eix[j*CW +: CW] = erv[j] ? CW'(c - 10 - j) : '0;
      end
      e = {eb, ed, ew, ewa, elr, ea, eaa, ecol, erv, eix};
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stream c=%0d outputs: got %h want %h", c, obs(), e);
      end
      n_chk++;
      if (busy_cycles !== 32'(c <= 16 ? c : 16)) begin
        n_fail++;
        $display("FAIL stream c=%0d busy_cycles: got %0d want %0d", c, busy_cycles, c <= 16 ? c : 16);
      end
      tick();
    end
  endtask
  task automatic test_zero_vec();
    launch(0);
    for (int c = 1; c <= 3; c++) begin
      n_chk++;
      if (obs() !== (c == 1 ? {2'b11, 61'd0} : 63'd0)) begin
        n_fail++;
        $display("FAIL zero_vec c=%0d outputs: got %h want %h", c, obs(), c == 1 ? {2'b11, 61'd0} : 63'd0);
      end
      n_chk++;
      if (busy_cycles !== 32'd1) begin
        n_fail++;
        $display("FAIL zero_vec c=%0d busy_cycles: got %0d want 1", c, busy_cycles);
      end
      tick();
    end
  endtask
  task automatic test_start_ignored();
    int dones = 0;
    launch(3);
    for (int c = 1; c <= 17; c++) begin
      start = c == 3 || c == 16 || c == 17;
      dones += int'(done);
      if (c == 4) begin
        n_chk++;
        if ({w_rd_en, w_rd_addr} !== 3'b111) begin
          n_fail++;
          $display("FAIL ignore c=4 weight read: got %b want 111", {w_rd_en, w_rd_addr});
        end
      end
      if (c == 17) begin
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore c=17 busy: got %b want 0", busy);
        end
      end
      tick();
    end
    start = 1'b0;
    n_chk++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL ignore done count: got %0d want 1", dones);
    end
    n_chk++;
    if ({busy, w_rd_en, w_rd_addr} !== 4'b1100) begin
      n_fail++;
      $display("FAIL ignore restart: got %b want 1100", {busy, w_rd_en, w_rd_addr});
    end
    wait_done("ignore", 40);
    tick();
  endtask
  task automatic test_overflow();
    launch(3);
    for (int c = 1; c <= 18; c++) begin
      ovf_in = c <= 9 ? 4'b1101 : c <= 12 ? 4'b1100 : 4'b0000;
      n_chk++;
      if (ovf_err !== (c >= 13)) begin
        n_fail++;
        $display("FAIL overflow c=%0d ovf_err: got %b want %b", c, ovf_err, c >= 13);
      end
      tick();
    end
    launch(1);
    n_chk++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow clear on start: got %b want 0", ovf_err);
    end
    wait_done("overflow", 40);
    tick();
  endtask
  task automatic test_async_reset();
    int dones = 0;
    launch(3);
    for (int c = 1; c < 7; c++) tick();
    n_chk++;
    if ({act_rd_en, act_rd_addr} !== {1'b1, CW'(2)}) begin
      n_fail++;
      $display("FAIL areset pre c=7 act: got %h want %h", {act_rd_en, act_rd_addr}, {1'b1, CW'(2)});
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({obs(), ovf_err, busy_cycles} !== '0) begin
      n_fail++;
      $display("FAIL areset immediate outputs: got %h want 0", {obs(), ovf_err, busy_cycles});
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      dones += int'(done);
      tick();
    end
    n_chk++;
    if (dones != 0 || obs() !== '0) begin
      n_fail++;
      $display("FAIL areset aborted job: got dones=%0d outputs=%h want 0 and 0", dones, obs());
    end
    launch(2);
    wait_done("areset", 40);
    n_chk++;
    if (busy_cycles !== 32'd15) begin
      n_fail++;
      $display("FAIL areset fresh job busy_cycles: got %0d want 15", busy_cycles);
    end
    tick();
  endtask
  task automatic test_saturate();
    int pulses = 0, addr_err = 0, k = 0;
    logic [CW-1:0] last_idx = '0;
    launch(MV + 5);
    while (!done && k < 400) begin
      if (act_rd_en) begin
        if (act_rd_addr !== CW'(pulses)) addr_err++;
        pulses++;
      end
      if (res_valid[N-1]) last_idx = row_idx(res_vec_idx, N - 1);
      tick();
      k++;
    end
    n_chk++;
    if (pulses != MV || addr_err != 0) begin
      n_fail++;
      $display("FAIL saturate reads: got %0d pulses, %0d bad addrs, want %0d and 0", pulses, addr_err, MV);
    end
    n_chk++;
    if (last_idx !== CW'(MV - 1)) begin
      n_fail++;
      $display("FAIL saturate last idx: got %0d want %0d", last_idx, MV - 1);
    end
    n_chk++;
    if (done !== 1'b1 || busy_cycles !== 32'(N + MV + 2 * N + 1)) begin
      n_fail++;
      $display("FAIL saturate done/busy_cycles: got %b/%0d want 1/%0d", done, busy_cycles, N + MV + 2 * N + 1);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_stream();
    test_zero_vec();
    test_start_ignored();
    test_overflow();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/sa_sched_ctrl.md
Name: sa_sched_ctrl

Overview:
Sequencing controller for an N x N weight-stationary systolic array of PE cells. Activations flow down and partial sums flow right; every PE has 1-cycle registered latency. On a start pulse the controller loads one weight row per cycle and streams num_vec activation vectors with per-column skew. It then drains the array, emitting per-row result-valid strobes with vector indices, and collects right-edge overflow flags. It sits between the host/DMA command interface and the PE array plus its weight, activation and result buffers.

Parameters:
N, 4, array dimension (rows = columns).
MAX_VEC, 256, maximum activation vectors per job.
CNT_W, $clog2(MAX_VEC+1), width of the vector count and index.
RW, $clog2(N), width of the weight row address.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  job request; sampled only in IDLE.
num_vec  in  CNT_W  vectors in the job; captured when start is accepted.
busy  out  1  high from the cycle after start is accepted through DONE inclusive.
done  out  1  one-cycle pulse in DONE.
w_rd_en  out  1  weight buffer read strobe.
w_rd_addr  out  RW  weight row being read.
w_load_row  out  N  one-hot PE-row weight latch, 1 cycle after the matching w_rd_en.
act_rd_en  out  1  activation buffer read strobe; data returns 1 cycle later.
act_rd_addr  out  CNT_W  activation vector index.
col_enable  out  N  per-column PE enable; bit j = feed delayed j cycles.
res_valid  out  N  bit i: right-edge output of row i is valid this cycle.
res_vec_idx  out  N*CNT_W  packed vector index for each row's current result.
ovf_in  in  N  overflow from the right-edge PE of each row.
ovf_err  out  1  sticky OR of ovf_in qualified by res_valid; cleared on start accept.
busy_cycles  out  32  cycles spent busy in the last or current job.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; delay lines and counters cleared. Reset mid-job aborts immediately, with no done.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE, start=1:
  - num_vec == 0: go to DONE with no reads.
  - num_vec > MAX_VEC: saturate to MAX_VEC.
  - otherwise: go to LOAD_W.
  - Accepting start clears ovf_err and busy_cycles.
- LOAD_W: N cycles. w_rd_en=1, w_rd_addr = 0..N-1. w_load_row = one-hot(addr) one cycle later. Then go to STREAM.
- STREAM: num_vec cycles. act_rd_en=1, act_rd_addr = 0..num_vec-1. Internal feed bit = act_rd_en delayed 1 cycle.
- Skew:
  - col_enable[j] = feed delayed j.
  - res_valid[i] = feed delayed i+N.
  - res_vec_idx[i] follows the same delay line as the address.
  - A vector read at cycle t yields row i valid at t+1+i+N.
- DRAIN: exactly 2N cycles after the last act_rd_en, then go to DONE. The last res_valid[N-1] coincides with the final DRAIN cycle.
- DONE: one cycle, done=1, then IDLE. busy falls in the cycle after DONE.
- start while busy is ignored, not queued. start in the same cycle as DONE is also ignored; accepted only in IDLE.
- busy_cycles increments every busy cycle and holds after done, saturating at 2^32-1.
- ovf_in is ignored when the matching res_valid bit is 0.

Decomposition:
- Package sa_pkg holds:
  - state enum sa_state_t.
  - N and CNT_W defaults.
  - A function for the packed index slice.
- One sub-module, sa_skew_line: a parameterised delay shift register carrying {valid, idx}. It is instantiated once of depth 2N, with taps for col_enable and res_valid/res_vec_idx.

Test Plan (N=4, start accepted at edge 0; cycle k = after edge k):
1. num_vec=3 ->
   - w_rd_en cycles 1-4; w_load_row 0001..1000 at cycles 2-5.
   - act_rd_en at 5,6,7, addr 0,1,2; col_enable[0] at 6-8; col_enable[3] at 9-11.
   - res_valid[0] at 10-12, idx 0,1,2; res_valid[3] at 13-15.
   - done at 16; busy 1-16; busy_cycles=16.
2. num_vec=0 -> done at cycle 1; busy only cycle 1; no w_rd_en or act_rd_en ever.
3. start pulsed again at cycles 3 and 16 during job 1 -> ignored; a single done; start at cycle 17 (IDLE) is accepted.
4. ovf_in[2]=1 while res_valid[2]=0 -> ovf_err stays 0. ovf_in[2]=1 at cycle 12 with res_valid[2]=1 -> ovf_err=1, held after done, cleared on the next start.
5. rst low at cycle 7 of job 1 -> all outputs 0 immediately (async); state IDLE; no done. A fresh start completes normally.
6. num_vec=MAX_VEC+5 -> exactly MAX_VEC act_rd_en pulses; act_rd_addr wraps never; final res_vec_idx=MAX_VEC-1.
